// File: rtl/bus_pkg.sv
// Shared definitions for the two-master strobe/ack bus arbiter.
package bus_pkg;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;

   // Read data returned to a master whose transfer was terminated by the watchdog
   localparam logic [DAT_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker: on a tie the master not granted last wins.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,   // 0: master 0 granted last, 1: master 1 granted last
   output logic [1:0] o_gnt     // one-hot pick, 2'b00 when nothing requested
);

   // Pick a single requester; ties broken against the last winner
   always_comb begin
      o_gnt = '0;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
         default: o_gnt = '0;
      endcase
   end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master / one-slave strobe-ack bus arbiter with round-robin priority
// and a bus-timeout watchdog. A dead IDLE cycle always separates grants.
module bus_arbiter2
   import bus_pkg::*;
#(
   parameter int unsigned            TIMEOUT_CYC = 16,            // minimum 2
   parameter logic [DAT_W-1:0]       ERR_DATA    = ERR_DATA_DEF
) (
   input  logic             iCLK,
   input  logic             iRST,
   // master 0
   input  logic             iM0_STB,
   input  logic             iM0_WE,
   input  logic [ADR_W-1:0] iM0_ADR,
   input  logic [DAT_W-1:0] iM0_DAT,
   output logic [DAT_W-1:0] oM0_DAT,
   output logic             oM0_ACK,
   output logic             oM0_ERR,
   // master 1
   input  logic             iM1_STB,
   input  logic             iM1_WE,
   input  logic [ADR_W-1:0] iM1_ADR,
   input  logic [DAT_W-1:0] iM1_DAT,
   output logic [DAT_W-1:0] oM1_DAT,
   output logic             oM1_ACK,
   output logic             oM1_ERR,
   // slave
   output logic             oS_STB,
   output logic             oS_WE,
   output logic [ADR_W-1:0] oS_ADR,
   output logic [DAT_W-1:0] oS_DAT,
   input  logic [DAT_W-1:0] iS_DAT,
   input  logic             iS_ACK,
   // status
   output logic [1:0]       oGNT
);

   localparam int unsigned   CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last;
   logic             w_last_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       w_pick;

   // selected-master view, valid only in a grant state
   logic             w_sel_stb;
   logic             w_sel_we;
   logic [ADR_W-1:0] w_sel_adr;
   logic [DAT_W-1:0] w_sel_dat;
   logic             w_ack;
   logic             w_err;
   logic [DAT_W-1:0] w_rdat;

   rr_arb2 u_rr (
      .i_req  ({iM1_STB, iM0_STB}),
      .i_last (r_last),
      .o_gnt  (w_pick)
   );

   // State, last-grant pointer and watchdog counter
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, termination decision and output muxing; the granted master's
   // request is resolved once (ACK > timeout > keep waiting) and then routed
   // back to whichever master owns the grant.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      w_sel_stb   = 1'b0;
      w_sel_we    = 1'b0;
      w_sel_adr   = '0;
      w_sel_dat   = '0;
      w_ack       = 1'b0;
      w_err       = 1'b0;
      w_rdat      = '0;
      oS_STB      = 1'b0;
      oS_WE       = 1'b0;
      oS_ADR      = '0;
      oS_DAT      = '0;
      oM0_ACK     = 1'b0;
      oM0_ERR     = 1'b0;
      oM0_DAT     = '0;
      oM1_ACK     = 1'b0;
      oM1_ERR     = 1'b0;
      oM1_DAT     = '0;
      oGNT        = 2'b00;

      case (r_state)
         ST_G0: begin
            w_sel_stb = iM0_STB;
            w_sel_we  = iM0_WE;
            w_sel_adr = iM0_ADR;
            w_sel_dat = iM0_DAT;
            oGNT      = 2'b01;
         end
         ST_G1: begin
            w_sel_stb = iM1_STB;
            w_sel_we  = iM1_WE;
            w_sel_adr = iM1_ADR;
            w_sel_dat = iM1_DAT;
            oGNT      = 2'b10;
         end
         default: ;
      endcase

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_pick == 2'b01) begin
               w_state_nxt = ST_G0;
               w_last_nxt  = 1'b0;
            end else if (w_pick == 2'b10) begin
               w_state_nxt = ST_G1;
               w_last_nxt  = 1'b1;
            end
         end
         ST_G0, ST_G1: begin
            if (w_sel_stb) begin
               oS_STB = 1'b1;
               oS_WE  = w_sel_we;
               oS_ADR = w_sel_adr;
               oS_DAT = w_sel_dat;
            end
            if (!w_sel_stb) begin
               // master withdrew: abort without ACK
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (iS_ACK) begin
               w_ack       = 1'b1;
               w_rdat      = w_sel_we ? '0 : iS_DAT;
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_ack       = 1'b1;
               w_err       = 1'b1;
               w_rdat      = w_sel_we ? '0 : ERR_DATA;
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (r_state == ST_G0) begin
         oM0_ACK = w_ack;
         oM0_ERR = w_err;
         oM0_DAT = w_rdat;
      end else if (r_state == ST_G1) begin
         oM1_ACK = w_ack;
         oM1_ERR = w_err;
         oM1_DAT = w_rdat;
      end
   end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: stimulus pushes expected terminations into
// a queue, a negedge monitor pops and compares on every master ACK.
module tb_bus_arbiter2;

   logic        iCLK;
   logic        iRST;
   logic        iM0_STB, iM0_WE, iM1_STB, iM1_WE;
   logic [31:0] iM0_ADR, iM0_DAT, iM1_ADR, iM1_DAT;
   logic [31:0] oM0_DAT, oM1_DAT;
   logic        oM0_ACK, oM0_ERR, oM1_ACK, oM1_ERR;
   logic        oS_STB, oS_WE;
   logic [31:0] oS_ADR, oS_DAT;
   logic [31:0] iS_DAT;
   logic        iS_ACK;
   logic [1:0]  oGNT;

   // slave model: 0 never acks, 1 acks with s_dat, 2 acks with address+1, 3 manual ack
   int          s_mode;
   logic [31:0] s_dat;
   logic        s_ack;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          m;
      logic        err;
      logic [31:0] dat;
      logic [1:0]  gnt;
   } exp_t;
   exp_t q[$];

   bus_arbiter2 #(.TIMEOUT_CYC(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iM0_STB (iM0_STB),
      .iM0_WE  (iM0_WE),
      .iM0_ADR (iM0_ADR),
      .iM0_DAT (iM0_DAT),
      .oM0_DAT (oM0_DAT),
      .oM0_ACK (oM0_ACK),
      .oM0_ERR (oM0_ERR),
      .iM1_STB (iM1_STB),
      .iM1_WE  (iM1_WE),
      .iM1_ADR (iM1_ADR),
      .iM1_DAT (iM1_DAT),
      .oM1_DAT (oM1_DAT),
      .oM1_ACK (oM1_ACK),
      .oM1_ERR (oM1_ERR),
      .oS_STB  (oS_STB),
      .oS_WE   (oS_WE),
      .oS_ADR  (oS_ADR),
      .oS_DAT  (oS_DAT),
      .iS_DAT  (iS_DAT),
      .iS_ACK  (iS_ACK),
      .oGNT    (oGNT)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   always_comb begin
      iS_ACK = 1'b0;
      iS_DAT = s_dat;
      case (s_mode)
         1: iS_ACK = oS_STB;
         2: begin
            iS_ACK = oS_STB;
            iS_DAT = oS_ADR + 32'd1;
         end
         3: iS_ACK = s_ack;
         default: iS_ACK = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int m, input logic err, input logic [31:0] dat, input logic [1:0] gnt);
      exp_t e;
      e.m   = m;
      e.err = err;
      e.dat = dat;
      e.gnt = gnt;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   // wait (bounded) for an ACK to master m; returns total and grant-cycle counts
   task automatic wait_ack(input int m, input int maxc, output int cyc, output int gcyc);
      bit seen;
      seen = 0;
      cyc  = 0;
      gcyc = 0;
      while (!seen && cyc < maxc) begin
         @(negedge iCLK);
         cyc++;
         if (oGNT == ((m == 0) ? 2'b01 : 2'b10)) gcyc++;
         if ((m == 0 && oM0_ACK) || (m == 1 && oM1_ACK)) seen = 1;
      end
      chk($sformatf("ack_seen_m%0d", m), 32'(seen), 32'd1);
   endtask

   // scoreboard monitor
   always @(negedge iCLK) begin
      if (!iRST && (oM0_ACK || oM1_ACK)) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_ack", {30'd0, oM1_ACK, oM0_ACK}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_m0_ack", 32'(oM0_ACK), 32'(e.m == 0));
            chk("sb_m1_ack", 32'(oM1_ACK), 32'(e.m == 1));
            chk("sb_gnt", 32'(oGNT), 32'(e.gnt));
            if (e.m == 0) begin
               chk("sb_m0_err", 32'(oM0_ERR), 32'(e.err));
               chk("sb_m0_dat", oM0_DAT, e.dat);
               chk("sb_m1_idle_dat", oM1_DAT, 32'd0);
               chk("sb_m1_idle_err", 32'(oM1_ERR), 32'd0);
            end else begin
               chk("sb_m1_err", 32'(oM1_ERR), 32'(e.err));
               chk("sb_m1_dat", oM1_DAT, e.dat);
               chk("sb_m0_idle_dat", oM0_DAT, 32'd0);
               chk("sb_m0_idle_err", 32'(oM0_ERR), 32'd0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, gc, n;
      iRST = 1'b1;
      s_mode = 0; s_dat = '0; s_ack = 1'b0;
      // masters active during reset: outputs must stay at reset values
      iM0_STB = 1'b1; iM0_WE = 1'b1; iM0_ADR = 32'h1234; iM0_DAT = 32'h5678;
      iM1_STB = 1'b1; iM1_WE = 1'b0; iM1_ADR = 32'h4321; iM1_DAT = 32'h8765;
      #12;
      chk("rst_s_stb", 32'(oS_STB), 32'd0);
      chk("rst_s_we",  32'(oS_WE),  32'd0);
      chk("rst_s_adr", oS_ADR, 32'd0);
      chk("rst_s_dat", oS_DAT, 32'd0);
      chk("rst_acks",  {28'd0, oM1_ERR, oM1_ACK, oM0_ERR, oM0_ACK}, 32'd0);
      chk("rst_m_dat", oM0_DAT | oM1_DAT, 32'd0);
      chk("rst_gnt",   32'(oGNT), 32'd0);
      iM0_STB = 1'b0; iM1_STB = 1'b0; iM0_WE = 1'b0;
      tick();
      iRST = 1'b0;

      // single master 0 read, zero-wait slave
      tick();
      s_mode = 1; s_dat = 32'h5A;
      iM0_ADR = 32'h0; iM0_WE = 1'b0; iM0_STB = 1'b1;
      push(0, 1'b0, 32'h0000_005A, 2'b01);
      wait_ack(0, 10, cyc, gc);
      chk("m0_latency", 32'(cyc), 32'd2);
      tick();
      iM0_STB = 1'b0;
      @(negedge iCLK);
      chk("m0_idle_after", 32'(oGNT), 32'd0);

      // single master 1 write
      tick();
      iM1_WE = 1'b1; iM1_ADR = 32'h40; iM1_DAT = 32'hCAFE_0001; iM1_STB = 1'b1;
      push(1, 1'b0, 32'h0, 2'b10);
      wait_ack(1, 10, cyc, gc);
      chk("wr_s_we",  32'(oS_WE), 32'd1);
      chk("wr_s_adr", oS_ADR, 32'h40);
      chk("wr_s_dat", oS_DAT, 32'hCAFE_0001);
      tick();
      iM1_STB = 1'b0; iM1_WE = 1'b0;

      // reset pulse: pointer returns to 1 so master 0 wins the next tie
      #2 iRST = 1'b1;
      #5 iRST = 1'b0;

      // simultaneous requests, two transfers each
      tick();
      s_mode = 2;
      iM0_ADR = 32'h100; iM1_ADR = 32'h200;
      iM0_STB = 1'b1; iM1_STB = 1'b1;
      push(0, 1'b0, 32'h101, 2'b01);
      push(1, 1'b0, 32'h201, 2'b10);
      push(0, 1'b0, 32'h105, 2'b01);
      push(1, 1'b0, 32'h205, 2'b10);
      for (int k = 0; k < 4; k++) begin
         wait_ack(k % 2, 10, cyc, gc);
         tick();
         if (k % 2 == 0) begin
            if (k < 2) iM0_ADR = 32'h104; else iM0_STB = 1'b0;
         end else begin
            if (k < 2) iM1_ADR = 32'h204; else iM1_STB = 1'b0;
         end
         @(negedge iCLK);
         chk("rr_dead_cycle", 32'(oGNT), 32'd0);
      end

      // timeout on master 1, then master 0 is served
      tick();
      s_mode = 0;
      iM1_WE = 1'b0; iM1_ADR = 32'h300; iM1_STB = 1'b1;
      push(1, 1'b1, 32'hDEAD_BEEF, 2'b10);
      wait_ack(1, 40, cyc, gc);
      chk("to_grant_cycles", 32'(gc), 32'd16);
      chk("to_stb_held", 32'(oS_STB), 32'd1);
      tick();
      iM1_STB = 1'b0;
      s_mode = 1; s_dat = 32'h77;
      iM0_ADR = 32'h8; iM0_STB = 1'b1;
      push(0, 1'b0, 32'h77, 2'b01);
      @(negedge iCLK);
      chk("to_idle_after", 32'(oGNT), 32'd0);
      wait_ack(0, 10, cyc, gc);
      tick();
      iM0_STB = 1'b0;

      // ACK arrives in the same cycle the watchdog would fire
      tick();
      s_mode = 3; s_ack = 1'b0; s_dat = 32'h12;
      iM0_ADR = 32'hC; iM0_STB = 1'b1;
      push(0, 1'b0, 32'h12, 2'b01);
      gc = 0; n = 0;
      while (gc < 15 && n < 40) begin
         @(negedge iCLK);
         n++;
         if (oGNT == 2'b01) gc++;
      end
      chk("co_no_early_ack", 32'(oM0_ACK), 32'd0);
      tick();
      s_ack = 1'b1;
      wait_ack(0, 3, cyc, gc);
      tick();
      s_ack = 1'b0; iM0_STB = 1'b0;

      // abort: master 0 drops STB in grant cycle 3, pending master 1 follows
      tick();
      s_mode = 0;
      iM0_ADR = 32'h10; iM0_STB = 1'b1;
      tick();
      iM1_ADR = 32'h20; iM1_WE = 1'b0; iM1_STB = 1'b1;
      push(1, 1'b0, 32'h99, 2'b10);
      tick();
      tick();
      iM0_STB = 1'b0;
      s_mode = 1; s_dat = 32'h99;
      @(negedge iCLK);
      chk("ab_gnt_held", 32'(oGNT), 32'd1);
      chk("ab_no_ack", 32'(oM0_ACK), 32'd0);
      @(negedge iCLK);
      chk("ab_idle", 32'(oGNT), 32'd0);
      wait_ack(1, 10, cyc, gc);
      tick();
      iM1_STB = 1'b0;

      // asynchronous reset in the middle of a G1 grant
      tick();
      s_mode = 0;
      iM1_ADR = 32'h30; iM1_STB = 1'b1;
      @(negedge iCLK);
      @(negedge iCLK);
      chk("rst_pre_gnt", 32'(oGNT), 32'd2);
      #2 iRST = 1'b1;
      #1;
      chk("rst_mid_s_stb", 32'(oS_STB), 32'd0);
      chk("rst_mid_gnt", 32'(oGNT), 32'd0);
      chk("rst_mid_ack", {30'd0, oM1_ACK, oM0_ACK}, 32'd0);
      iM1_STB = 1'b0;
      tick();
      iRST = 1'b0;
      tick();
      s_mode = 1; s_dat = 32'h55;
      iM0_ADR = 32'h50; iM1_ADR = 32'h60;
      iM0_STB = 1'b1; iM1_STB = 1'b1;
      push(0, 1'b0, 32'h55, 2'b01);
      push(1, 1'b0, 32'h55, 2'b10);
      wait_ack(0, 10, cyc, gc);
      tick();
      iM0_STB = 1'b0;
      wait_ack(1, 10, cyc, gc);
      tick();
      iM1_STB = 1'b0;

      repeat (3) tick();
      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
